// File: rtl/lsu_mem_if.sv
// Load/store stage in front of a 4-lane byte-write RAM; store/error respond 1 cycle after accept, loads 3.
// No response backpressure; req_ready is high only when idle and requests seen while busy are dropped.
module lsu_mem_if #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic [3:0]    ram_wen,
  output logic [AW-1:0] ram_w_addr,
  output logic [DW-1:0] ram_w_data,
  output logic          ram_ren,
  output logic [AW-1:0] ram_r_addr,
  input  logic [DW-1:0] ram_r_data
);

  typedef enum logic [2:0] {IDLE, ST, LD_REQ, LD_CAP, RESP, ERR} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_req_ready, r_resp_valid, r_resp_err, r_ram_ren;
  logic [DW-1:0] r_resp_rdata, r_ram_w_data;
  logic [3:0]    r_ram_wen;
  logic [AW-1:0] r_ram_w_addr, r_ram_r_addr;
  logic [1:0]    r_size, r_lane;
  logic          r_unsigned;

  logic          w_accept, w_misalign, w_resp_valid, w_resp_err, w_ren;
  logic [DW-1:0] w_resp_rdata, w_w_data, w_rep_data, w_ld_ext;
  logic [3:0]    w_wen, w_mask;
  logic [AW-1:0] w_w_addr, w_r_addr, w_word_addr;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign ram_wen    = r_ram_wen;
  assign ram_w_addr = r_ram_w_addr;
  assign ram_w_data = r_ram_w_data;
  assign ram_ren    = r_ram_ren;
  assign ram_r_addr = r_ram_r_addr;

  assign w_accept    = (r_state == IDLE) && req_valid;
  assign w_word_addr = {req_addr[AW-1:2], 2'b00};
  assign w_misalign  = (req_size == 2'd3) ||
                       (req_size == 2'd1 && req_addr[0]) ||
                       (req_size == 2'd2 && req_addr[1:0] != 2'b00);

  always_comb begin
    w_mask     = 4'b1111;
    w_rep_data = req_wdata;
    case (req_size)
      2'd0: begin
        w_mask     = 4'b0001 << req_addr[1:0];
        w_rep_data = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        w_mask     = req_addr[1] ? 4'b1100 : 4'b0011;
        w_rep_data = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane select uses the fields latched at acceptance; RAM data is valid in LD_CAP.
  always_comb begin
    w_byte   = ram_r_data[{r_lane, 3'b000} +: 8];
    w_half   = r_lane[1] ? ram_r_data[31:16] : ram_r_data[15:0];
    w_ld_ext = ram_r_data;
    case (r_size)
      2'd0:    w_ld_ext = {{(DW-8){~r_unsigned & w_byte[7]}}, w_byte};
      2'd1:    w_ld_ext = {{(DW-16){~r_unsigned & w_half[15]}}, w_half};
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_resp_valid = 1'b0;
    w_resp_err   = r_resp_err;
    w_resp_rdata = r_resp_rdata;
    w_wen        = 4'b0000;
    w_ren        = 1'b0;
    w_w_addr     = r_ram_w_addr;
    w_w_data     = r_ram_w_data;
    w_r_addr     = r_ram_r_addr;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_misalign) begin
            w_state_nxt  = ERR;
            w_resp_valid = 1'b1;
            w_resp_err   = 1'b1;
            w_resp_rdata = '0;
          end else if (req_we) begin
            w_state_nxt  = ST;
            w_wen        = w_mask;
            w_w_addr     = w_word_addr;
            w_w_data     = w_rep_data;
            w_resp_valid = 1'b1;
            w_resp_err   = 1'b0;
            w_resp_rdata = '0;
          end else begin
            w_state_nxt = LD_REQ;
            w_ren       = 1'b1;
            w_r_addr    = w_word_addr;
          end
        end
      end
      LD_REQ: w_state_nxt = LD_CAP;
      LD_CAP: begin
        w_state_nxt  = RESP;
        w_resp_valid = 1'b1;
        w_resp_err   = 1'b0;
        w_resp_rdata = w_ld_ext;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_ram_wen    <= 4'b0000;
      r_ram_w_addr <= '0;
      r_ram_w_data <= '0;
      r_ram_ren    <= 1'b0;
      r_ram_r_addr <= '0;
      r_size       <= 2'd0;
      r_lane       <= 2'd0;
      r_unsigned   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_req_ready  <= (w_state_nxt == IDLE);
      r_resp_valid <= w_resp_valid;
      r_resp_err   <= w_resp_err;
      r_resp_rdata <= w_resp_rdata;
      r_ram_wen    <= w_wen;
      r_ram_w_addr <= w_w_addr;
      r_ram_w_data <= w_w_data;
      r_ram_ren    <= w_ren;
      r_ram_r_addr <= w_r_addr;
      if (w_accept) begin
        r_size     <= req_size;
        r_lane     <= req_addr[1:0];
        r_unsigned <= req_unsigned;
      end
    end
  end

endmodule
